p4_router_ingress_arbiter: RTL and testbench

Packet-level round-robin arbiter that merges NUM_ING_PORTS ingress AXIS streams into the single packet_data_in stream of p4_router_vnp4_wrapper_select. It generates the wrapper's user_metadata_in_ing_port and user_metadata_in_valid sideband on each packet's first beat. Grants are held until tlast so packets are never interleaved. Per-port enables and packet counters support software bring-up and debug.

---
 rtl/p4_router_ingress_arbiter_if.sv | 16 +
 rtl/p4_router_ingress_arbiter.sv | 144 ++++++++++++++
 tb/tb_p4_router_ingress_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p4_router_ingress_arbiter_if.sv
// AXI-Stream bundle used for every ingress stream and for the merged egress
// stream towards the VNP4 wrapper.
interface AXIS_int #(
  parameter int DATA_BYTES = 64,
  parameter int USER_WIDTH = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_BYTES*8-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;

  modport Master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport Slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/p4_router_ingress_arbiter.sv
// Packet-level round-robin arbiter: merges the ingress streams into the single
// wrapper input stream, holds each grant until tlast, and emits the ingress
// port sideband on the first beat of every packet.
//
// state | meaning
// IDLE  | no packet in flight; pick the next eligible port after last_grant
// PASS  | granted port is muxed straight through until its tlast beat
module p4_router_ingress_arbiter #(
  parameter int NUM_ING_PORTS           = 4,
  parameter int DATA_BYTES              = 64,
  parameter int USER_WIDTH              = 1,
  parameter int ING_PORT_METADATA_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               sresetn,
  AXIS_int.Slave                             ing_port_in [NUM_ING_PORTS],
  input  logic [NUM_ING_PORTS-1:0]           port_enable,
  AXIS_int.Master                            packet_data_out,
  output logic [ING_PORT_METADATA_WIDTH-1:0] user_metadata_out_ing_port,
  output logic                               user_metadata_out_valid,
  output logic [15:0]                        pkt_count [NUM_ING_PORTS],
  output logic                               busy
);

  localparam int GW = (NUM_ING_PORTS > 1) ? $clog2(NUM_ING_PORTS) : 1;

  if (NUM_ING_PORTS < 2 || NUM_ING_PORTS > 16) begin : g_bad_num_ports
    $error("NUM_ING_PORTS must be within 2..16");
  end
  if (ING_PORT_METADATA_WIDTH < GW) begin : g_bad_meta_width
    $error("ING_PORT_METADATA_WIDTH too narrow for the port index");
  end
  if (DATA_BYTES < 1) begin : g_bad_data_bytes
    $error("DATA_BYTES must be at least 1");
  end

  typedef enum logic {IDLE, PASS} state_t;

  state_t                         state, state_nxt;
  logic [GW-1:0]                  grant, grant_nxt;
  logic [GW-1:0]                  last_grant, last_grant_nxt;
  logic                           sop, sop_nxt;
  logic [NUM_ING_PORTS-1:0][15:0] cnt;

  logic [NUM_ING_PORTS-1:0] in_tvalid, in_tlast, in_tready, eligible;
  logic [DATA_BYTES*8-1:0]  in_tdata [NUM_ING_PORTS];
  logic [DATA_BYTES-1:0]    in_tkeep [NUM_ING_PORTS];
  logic [USER_WIDTH-1:0]    in_tuser [NUM_ING_PORTS];

  logic          pick_valid;
  logic [GW-1:0] pick, cand;
  int            idx;
  logic          accept, eop;

  // Flatten the interface array so the granted port can be selected by index.
  for (genvar g = 0; g < NUM_ING_PORTS; g++) begin : g_port
    assign in_tvalid[g]          = ing_port_in[g].tvalid;
    assign in_tlast[g]           = ing_port_in[g].tlast;
    assign in_tdata[g]           = ing_port_in[g].tdata;
    assign in_tkeep[g]           = ing_port_in[g].tkeep;
    assign in_tuser[g]           = ing_port_in[g].tuser;
    assign ing_port_in[g].tready = in_tready[g];
    assign pkt_count[g]          = cnt[g];
  end

  assign eligible = in_tvalid & port_enable;
  assign accept   = packet_data_out.tvalid & packet_data_out.tready;
  assign eop      = accept & packet_data_out.tlast;

  // Cyclic search from last_grant+1; the nearest eligible port is visited last so it wins.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    cand       = '0;
    idx        = 0;
    for (int i = NUM_ING_PORTS; i >= 1; i--) begin
      idx  = (int'(last_grant) + i) % NUM_ING_PORTS;
      cand = GW'(idx);
      if (eligible[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // Data path: zero-latency mux of the granted port; nothing flows while idle.
  always_comb begin
    packet_data_out.tvalid = 1'b0;
    packet_data_out.tdata  = in_tdata[grant];
    packet_data_out.tkeep  = in_tkeep[grant];
    packet_data_out.tlast  = in_tlast[grant];
    packet_data_out.tuser  = in_tuser[grant];
    in_tready              = '0;
    if (state == PASS) begin
      packet_data_out.tvalid = in_tvalid[grant];
      in_tready[grant]       = packet_data_out.tready;
    end
  end

  // Next-state logic; port_enable is only consulted when choosing a new grant.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    sop_nxt        = sop;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt      = PASS;
          grant_nxt      = pick;
          last_grant_nxt = pick;
          sop_nxt        = 1'b1;
        end
      end
      PASS: begin
        if (accept) sop_nxt = 1'b0;
        if (eop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant and per-port packet counters; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_ING_PORTS - 1);
      sop        <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      sop        <= sop_nxt;
      if (eop) cnt[grant] <= cnt[grant] + 16'd1;
    end
  end

  assign busy                       = (state == PASS);
  assign user_metadata_out_valid    = sop & packet_data_out.tvalid;
  assign user_metadata_out_ing_port = (state == PASS) ? ING_PORT_METADATA_WIDTH'(grant) : '0;

endmodule

// File: tb/tb_p4_router_ingress_arbiter.sv
// Bench for the ingress arbiter: a per-cycle vector table for the basic
// arbitration rules, then packet-level sequences for the multi-cycle cases.
module tb_p4_router_ingress_arbiter;
  localparam int N  = 4;
  localparam int DB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           sresetn;
  logic [N-1:0]   port_enable;
  logic [7:0]     meta_port;
  logic           meta_valid;
  logic [15:0]    pkt_count [N];
  logic           busy;
  logic [N-1:0]   src_valid, src_last, src_ready, src_user;
  logic [DB*8-1:0] src_data [N];
  logic [DB-1:0]  src_keep [N];
  logic           out_ready;

  AXIS_int #(.DATA_BYTES(DB)) ing [N] ();
  AXIS_int #(.DATA_BYTES(DB)) out_if ();

  for (genvar g = 0; g < N; g++) begin : g_src
    assign ing[g].tvalid = src_valid[g];
    assign ing[g].tdata  = src_data[g];
    assign ing[g].tkeep  = src_keep[g];
    assign ing[g].tlast  = src_last[g];
    assign ing[g].tuser  = src_user[g];
    assign src_ready[g]  = ing[g].tready;
  end
  assign out_if.tready = out_ready;

  p4_router_ingress_arbiter #(
    .NUM_ING_PORTS(N), .DATA_BYTES(DB), .USER_WIDTH(1), .ING_PORT_METADATA_WIDTH(8)
  ) dut (
    .clk(clk),
    .sresetn(sresetn),
    .ing_port_in(ing),
    .port_enable(port_enable),
    .packet_data_out(out_if),
    .user_metadata_out_ing_port(meta_port),
    .user_metadata_out_valid(meta_valid),
    .pkt_count(pkt_count),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- per-cycle vector table ----------------
  typedef struct {
    logic       rst_n;
    logic [3:0] vld, lst, en;
    logic       ordy;
    logic       e_busy, e_ov, e_mv;
    logic [7:0] e_mp;
    logic [3:0] e_tr;
  } vec_t;
  vec_t vt [17];

  // ---------------- packet source model ----------------
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } cap_t;

  int unsigned pq [N][$];
  int unsigned bidx [N];
  int unsigned pnum [N];
  cap_t        cap_q[$];
  cap_t        exp_q[$];
  int          mq[$];
  int          mcyc[$];
  int          cyc;
  bit          toggle_rdy;
  bit          seen_acc;
  int          late_meta;
  int          first_nometa;

  function automatic logic [31:0] beat_word(int p, int k, int b);
    return {8'(p), 8'(k), 8'(b), 8'h5A};
  endfunction

  task automatic push_exp(int p, int k, int len);
    cap_t e;
    for (int b = 0; b < len; b++) begin
      e.d = beat_word(p, k, b);
      e.l = (b == len - 1);
      e.k = e.l ? 4'b0011 : 4'b1111;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_src();
    for (int p = 0; p < N; p++) begin
      if (pq[p].size() > 0) begin
        src_valid[p] = 1'b1;
        src_data[p]  = beat_word(p, int'(pnum[p]), int'(bidx[p]));
        src_last[p]  = (bidx[p] == pq[p][0] - 1);
        src_keep[p]  = src_last[p] ? 4'b0011 : 4'b1111;
        src_user[p]  = (bidx[p] == 0);
      end else begin
        src_valid[p] = 1'b0;
        src_data[p]  = '0;
        src_last[p]  = 1'b0;
        src_keep[p]  = '0;
        src_user[p]  = 1'b0;
      end
    end
  endtask

  function automatic bit pending();
    for (int p = 0; p < N; p++)
      if (pq[p].size() > 0 && port_enable[p]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: sample combinational outputs at negedge, advance sources after the edge.
  task automatic tick();
    logic [N-1:0] hs;
    cap_t c;
    @(negedge clk);
    hs = src_valid & src_ready;
    if (meta_valid) begin
      mq.push_back(int'(meta_port));
      mcyc.push_back(cyc);
      if (seen_acc) late_meta++;
    end
    if (out_if.tvalid && out_ready) begin
      c.d = out_if.tdata;
      c.k = out_if.tkeep;
      c.l = out_if.tlast;
      cap_q.push_back(c);
      if (!seen_acc && !meta_valid) first_nometa++;
      seen_acc = !out_if.tlast;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < N; p++) begin
      if (hs[p]) begin
        bidx[p]++;
        if (bidx[p] == pq[p][0]) begin
          pq[p].delete(0);
          bidx[p] = 0;
          pnum[p]++;
        end
      end
    end
    if (toggle_rdy) out_ready = ~out_ready;
    drive_src();
  endtask

  task automatic run(input string name, input int max_cyc);
    int c;
    c = 0;
    while ((pending() || busy) && c < max_cyc) begin
      tick();
      c++;
    end
    n_cmp++;
    if (c >= max_cyc) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d cycles, expected fewer than %0d", name, c, max_cyc);
    end
  endtask

  task automatic clear_logs();
    cap_q.delete();
    exp_q.delete();
    mq.delete();
    mcyc.delete();
    seen_acc     = 1'b0;
    late_meta    = 0;
    first_nometa = 0;
  endtask

  task automatic do_reset();
    for (int p = 0; p < N; p++) begin
      pq[p].delete();
      bidx[p] = 0;
      pnum[p] = 0;
    end
    port_enable = '1;
    out_ready   = 1'b1;
    toggle_rdy  = 1'b0;
    drive_src();
    clear_logs();
    sresetn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    sresetn = 1'b1;
    cyc = 0;
  endtask

  task automatic check_stream(input string name);
    check($sformatf("%s_beats", name), 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      check($sformatf("%s_data%0d", name, i), 64'(cap_q[i].d), 64'(exp_q[i].d));
      check($sformatf("%s_keep%0d", name, i), 64'(cap_q[i].k), 64'(exp_q[i].k));
      check($sformatf("%s_last%0d", name, i), 64'(cap_q[i].l), 64'(exp_q[i].l));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst vld  lst  en   rdy | busy ov mv mp    tr
    vt[0]  = '{1'b0, 4'hF, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0};
    vt[1]  = '{1'b1, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0};
    vt[2]  = '{1'b1, 4'hA, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0};
    vt[3]  = '{1'b1, 4'hA, 4'h2, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 4'h2};
    vt[4]  = '{1'b1, 4'hA, 4'h8, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0};
    vt[5]  = '{1'b1, 4'hA, 4'h0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 4'h0};
    vt[6]  = '{1'b1, 4'hA, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 4'h8};
    vt[7]  = '{1'b1, 4'h2, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 4'h8};
    vt[8]  = '{1'b1, 4'hA, 4'h8, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 4'h8};
    vt[9]  = '{1'b1, 4'hA, 4'h0, 4'hD, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0};
    vt[10] = '{1'b1, 4'hA, 4'h8, 4'hD, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 4'h8};
    vt[11] = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0};
    vt[12] = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0};
    vt[13] = '{1'b1, 4'hF, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0};
    vt[14] = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 4'h1};
    vt[15] = '{1'b1, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 4'h1};
    vt[16] = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'h0};

    for (int p = 0; p < N; p++) begin
      src_data[p] = 32'hA0 + 32'(p);
      src_keep[p] = 4'hF;
    end
    src_user   = '0;
    toggle_rdy = 1'b0;
    cyc        = 0;

    for (int i = 0; i < 17; i++) begin
      sresetn     = vt[i].rst_n;
      src_valid   = vt[i].vld;
      src_last    = vt[i].lst;
      port_enable = vt[i].en;
      out_ready   = vt[i].ordy;
      @(negedge clk);
      check($sformatf("v%0d_busy", i), 64'(busy), 64'(vt[i].e_busy));
      check($sformatf("v%0d_tvalid", i), 64'(out_if.tvalid), 64'(vt[i].e_ov));
      check($sformatf("v%0d_meta_valid", i), 64'(meta_valid), 64'(vt[i].e_mv));
      check($sformatf("v%0d_meta_port", i), 64'(meta_port), 64'(vt[i].e_mp));
      check($sformatf("v%0d_tready", i), 64'(src_ready), 64'(vt[i].e_tr));
      if (vt[i].e_ov) begin
        check($sformatf("v%0d_tdata", i), 64'(out_if.tdata), 64'(32'hA0 + 32'(vt[i].e_mp)));
        check($sformatf("v%0d_tlast", i), 64'(out_if.tlast), 64'(vt[i].lst[vt[i].e_mp[1:0]]));
      end
      @(posedge clk);
      #1;
    end
    check("table_cnt0", 64'(pkt_count[0]), 64'd1);
    check("table_cnt1", 64'(pkt_count[1]), 64'd1);
    check("table_cnt2", 64'(pkt_count[2]), 64'd0);
    check("table_cnt3", 64'(pkt_count[3]), 64'd2);

    // Single port, a 3-beat then a 1-beat packet.
    do_reset();
    pq[2].push_back(3);
    pq[2].push_back(1);
    drive_src();
    run("single", 40);
    push_exp(2, 0, 3);
    push_exp(2, 1, 1);
    check_stream("single");
    check("single_meta_n", 64'(mq.size()), 64'd2);
    if (mq.size() == 2) begin
      check("single_meta_p0", 64'(mq[0]), 64'd2);
      check("single_meta_p1", 64'(mq[1]), 64'd2);
      check("single_gap", 64'(mcyc[1] - mcyc[0]), 64'd4);
    end
    check("single_cnt2", 64'(pkt_count[2]), 64'd2);

    // Round robin across ports 0,1,3 with 2-beat packets.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pq[0].push_back(2);
      pq[1].push_back(2);
      pq[3].push_back(2);
    end
    drive_src();
    run("rr", 100);
    for (int k = 0; k < 9; k++) push_exp((k % 3 == 2) ? 3 : k % 3, k / 3, 2);
    check_stream("rr");
    check("rr_meta_n", 64'(mq.size()), 64'd9);
    for (int k = 0; k < 9 && k < mq.size(); k++)
      check($sformatf("rr_grant%0d", k), 64'(mq[k]), 64'((k % 3 == 2) ? 3 : k % 3));
    check("rr_cnt0", 64'(pkt_count[0]), 64'd3);
    check("rr_cnt1", 64'(pkt_count[1]), 64'd3);
    check("rr_cnt2", 64'(pkt_count[2]), 64'd0);
    check("rr_cnt3", 64'(pkt_count[3]), 64'd3);

    // Backpressure: output tready toggles every cycle during a 5-beat packet.
    do_reset();
    toggle_rdy = 1'b1;
    pq[1].push_back(5);
    drive_src();
    run("bp", 60);
    toggle_rdy = 1'b0;
    out_ready  = 1'b1;
    push_exp(1, 0, 5);
    check_stream("bp");
    check("bp_meta_n", 64'(mq.size()), 64'd2);
    check("bp_meta_late", 64'(late_meta), 64'd0);
    check("bp_meta_first", 64'(first_nometa), 64'd0);
    check("bp_cnt1", 64'(pkt_count[1]), 64'd1);

    // Enable cleared mid-packet on port 0 while port 1 waits.
    do_reset();
    pq[0].push_back(4);
    pq[0].push_back(2);
    pq[1].push_back(2);
    drive_src();
    tick();
    tick();
    port_enable = 4'b1110;
    run("en", 40);
    repeat (6) tick();
    push_exp(0, 0, 4);
    push_exp(1, 0, 2);
    check_stream("en");
    check("en_busy", 64'(busy), 64'd0);
    check("en_port0_left", 64'(pq[0].size()), 64'd1);
    check("en_cnt0", 64'(pkt_count[0]), 64'd1);
    port_enable = '1;
    clear_logs();
    run("reen", 20);
    push_exp(0, 1, 2);
    check_stream("reen");

    // Reset asserted on beat 2 of a 4-beat packet.
    do_reset();
    pq[3].push_back(1);
    drive_src();
    run("rst_pre", 20);
    check("rst_pre_cnt3", 64'(pkt_count[3]), 64'd1);
    pq[2].push_back(4);
    drive_src();
    tick();
    tick();
    sresetn = 1'b0;
    @(posedge clk);
    #1;
    sresetn = 1'b1;
    pq[2].delete();
    bidx[2] = 0;
    pq[1].push_back(1);
    pq[0].push_back(1);
    drive_src();
    clear_logs();
    @(negedge clk);
    check("rst_tvalid", 64'(out_if.tvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_meta_valid", 64'(meta_valid), 64'd0);
    check("rst_tready", 64'(src_ready), 64'd0);
    for (int p = 0; p < N; p++) check($sformatf("rst_cnt%0d", p), 64'(pkt_count[p]), 64'd0);
    @(posedge clk);
    #1;
    run("rst_post", 20);
    check("rst_post_meta_n", 64'(mq.size()), 64'd2);
    if (mq.size() == 2) begin
      check("rst_post_first", 64'(mq[0]), 64'd0);
      check("rst_post_second", 64'(mq[1]), 64'd1);
    end

    // Counter wrap: preload 65534 packets on port 3, then send 3 more (65537 total).
    do_reset();
    force dut.cnt = {16'hFFFE, 48'h0};
    @(negedge clk);
    release dut.cnt;
    @(posedge clk);
    #1;
    pq[3].push_back(1);
    pq[3].push_back(1);
    drive_src();
    run("wrap_a", 20);
    check("wrap_cnt3_zero", 64'(pkt_count[3]), 64'd0);
    pq[3].push_back(1);
    drive_src();
    run("wrap_b", 20);
    check("wrap_cnt3_one", 64'(pkt_count[3]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
